// File: rtl/ro_scan_pkg.sv
// ro_scan_pkg: shared types and constants for the ring-oscillator scan
// sequencer.
//   scan_state_e   - sequencer FSM states
//   FRAME_PREAMBLE - 4-bit frame sync pattern, sent first
//   CRC4_POLY      - x^4+x+1, with the implicit x^4 term dropped
//   frame_width()  - total frame bits for a given counter width
//   crc4_step()    - one serial CRC-4 update (MSB-first data)
package ro_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_SETTLE, S_SHIFT, S_GAP, S_DONE
  } scan_state_e;

  localparam logic [3:0] FRAME_PREAMBLE = 4'b1010;
  localparam logic [3:0] CRC4_POLY      = 4'h3;

  // preamble + channel id + count + crc
  function automatic int frame_width(input int counter_length);
    return 4 + 2 + counter_length + 4;
  endfunction

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
  endfunction

endpackage

// File: rtl/ro_frame_serializer.sv
// ro_frame_serializer: emits one framed record, MSB first:
//   preamble(4) | id(2) | count(COUNTER_LENGTH) | crc4(4)
// The CRC accumulates while id+count leave the shift register and is
// shifted out straight after the payload, so there is no bubble.
// Ports:
//   clk, reset  - clock, synchronous active-high clear (also used to abort)
//   load        - start a new frame on this edge with id/count
//   id, count   - frame payload
//   tx_bit      - current frame bit, 0 when idle
//   valid       - high for the FRAME_W cycles of the frame
//   last        - high on the final frame bit
module ro_frame_serializer
  import ro_scan_pkg::*;
#(
  parameter int COUNTER_LENGTH = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [1:0]                id,
  input  logic [COUNTER_LENGTH-1:0] count,
  output logic                      tx_bit,
  output logic                      valid,
  output logic                      last
);

  localparam int FRAME_W = frame_width(COUNTER_LENGTH);
  localparam int PAY_W   = 2 + COUNTER_LENGTH;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] PAY_START = CW'(4);
  localparam logic [CW-1:0] PAY_END   = CW'(4 + PAY_W);
  localparam logic [CW-1:0] LAST_POS  = CW'(FRAME_W - 1);

  logic             active;
  logic [CW-1:0]    pos;
  logic [PAY_W-1:0] pay;
  logic [3:0]       crc;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      pos    <= '0;
      pay    <= '0;
      crc    <= '0;
    end else if (load) begin
      active <= 1'b1;
      pos    <= '0;
      pay    <= {id, count};
      crc    <= '0;
    end else if (active) begin
      pos <= pos + CW'(1);
      if (pos == LAST_POS) active <= 1'b0;
      if (pos >= PAY_START && pos < PAY_END) begin
        pay <= {pay[PAY_W-2:0], 1'b0};
        crc <= crc4_step(crc, pay[PAY_W-1]);
      end else if (pos >= PAY_END) begin
        crc <= {crc[2:0], 1'b0};
      end
    end
  end

  always_comb begin
    tx_bit = 1'b0;
    if (active) begin
      if (pos < PAY_START)    tx_bit = FRAME_PREAMBLE[~pos[1:0]];
      else if (pos < PAY_END) tx_bit = pay[PAY_W-1];
      else                    tx_bit = crc[3];
    end
  end

  assign valid = active;
  assign last  = active && (pos == LAST_POS);

endmodule

// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer: autonomous ring-oscillator measurement sequencer.
// Each scan clears the counters, opens a gate window, latches the counts,
// waits for the counter-side synchronizer, snapshots all channels at once
// and sends one CRC-protected frame per channel with a 1-cycle gap.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   ena            - low aborts to IDLE on the next edge
//   start          - scan request, only looked at in IDLE
//   continuous     - restart automatically after DONE
//   gate_cycles    - gate window length (0 behaves as 1)
//   counts         - latched counter values, channel i at [i*CL +: CL]
//   ctr_reset      - counter clear request (CLEAR)
//   latch_counter  - counter latch request (LATCH)
//   serial_bit/serial_valid/frame_start - frame stream
//   busy           - not IDLE
//   done           - 1-cycle end-of-scan pulse
module ro_scan_sequencer
  import ro_scan_pkg::*;
#(
  parameter int COUNTER_LENGTH = 20,
  parameter int NR_CHANNELS    = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CLEAR_CYCLES   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ena,
  input  logic                                  start,
  input  logic                                  continuous,
  input  logic [15:0]                           gate_cycles,
  input  logic [NR_CHANNELS*COUNTER_LENGTH-1:0] counts,
  output logic                                  ctr_reset,
  output logic                                  latch_counter,
  output logic                                  serial_bit,
  output logic                                  serial_valid,
  output logic                                  frame_start,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CL = COUNTER_LENGTH;
  localparam logic [1:0]  LAST_CH  = 2'(NR_CHANNELS - 1);
  localparam logic [15:0] CLEAR_LD = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);

  scan_state_e               state, state_d;
  logic [15:0]               tmr, tmr_d;
  logic [15:0]               gate_q;
  logic [1:0]                idx, idx_d;
  logic [NR_CHANNELS*CL-1:0] snap;
  logic                      ld, snap_en, cap_gate;
  logic                      fs_q;
  logic [CL-1:0]             ld_count;
  logic                      ser_rst, ser_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      tmr    <= '0;
      gate_q <= 16'd1;
      idx    <= '0;
      snap   <= '0;
      fs_q   <= 1'b0;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
      idx   <= idx_d;
      fs_q  <= ld;
      if (cap_gate) gate_q <= (gate_cycles == 16'd0) ? 16'd1 : gate_cycles;
      if (snap_en)  snap   <= counts;
    end
  end

  // Each timed state loads tmr with (length-1) on entry and leaves at 0.
  always_comb begin
    state_d  = state;
    tmr_d    = (tmr == 16'd0) ? 16'd0 : tmr - 16'd1;
    idx_d    = idx;
    ld       = 1'b0;
    snap_en  = 1'b0;
    cap_gate = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        state_d  = S_CLEAR;
        tmr_d    = CLEAR_LD;
        cap_gate = 1'b1;
        idx_d    = '0;
      end
      S_CLEAR: if (tmr == 16'd0) begin
        state_d = S_GATE;
        tmr_d   = gate_q - 16'd1;
      end
      S_GATE: if (tmr == 16'd0) begin
        state_d = S_LATCH;
        tmr_d   = SETTLE_LD;
      end
      S_LATCH: if (tmr == 16'd0) begin
        state_d = S_SETTLE;
        tmr_d   = SETTLE_LD;
      end
      // Snapshot and first-frame load share one edge; channel 0 is fed
      // straight from counts since snap only updates at that edge.
      S_SETTLE: if (tmr == 16'd0) begin
        state_d = S_SHIFT;
        snap_en = 1'b1;
        ld      = 1'b1;
        idx_d   = '0;
      end
      S_SHIFT: if (ser_last) state_d = S_GAP;
      S_GAP: begin
        if (idx < LAST_CH) begin
          state_d = S_SHIFT;
          idx_d   = idx + 2'd1;
          ld      = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d  = S_CLEAR;
          tmr_d    = CLEAR_LD;
          cap_gate = 1'b1;
          idx_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!ena) begin
      state_d  = S_IDLE;
      ld       = 1'b0;
      snap_en  = 1'b0;
      cap_gate = 1'b0;
    end
  end

  assign ld_count = (state == S_SETTLE) ? counts[CL-1:0] : snap[idx_d*CL +: CL];
  assign ser_rst  = reset | ~ena;

  ro_frame_serializer #(.COUNTER_LENGTH(CL)) u_ser (
    .clk   (clk),
    .reset (ser_rst),
    .load  (ld),
    .id    (idx_d),
    .count (ld_count),
    .tx_bit(serial_bit),
    .valid (serial_valid),
    .last  (ser_last)
  );

  assign frame_start   = fs_q;
  assign ctr_reset     = (state == S_CLEAR);
  assign latch_counter = (state == S_LATCH);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// tb_ro_scan_sequencer: directed table-driven bench for ro_scan_sequencer
// with an independent CRC-4 model (polynomial long division), plus
// hand-written sequences for reset/start, continuous mode and abort.
module tb_ro_scan_sequencer;
  localparam int CL  = 20;
  localparam int NCH = 3;
  localparam int FW  = 30;

  logic             clk = 1'b0;
  logic             reset, ena, start, continuous;
  logic [15:0]      gate_cycles;
  logic [NCH*CL-1:0] counts;
  logic ctr_reset, latch_counter, serial_bit, serial_valid, frame_start, busy, done;

  ro_scan_sequencer #(.COUNTER_LENGTH(CL), .NR_CHANNELS(NCH),
                      .SETTLE_CYCLES(4), .CLEAR_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .continuous(continuous),
    .gate_cycles(gate_cycles), .counts(counts), .ctr_reset(ctr_reset),
    .latch_counter(latch_counter), .serial_bit(serial_bit),
    .serial_valid(serial_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // CRC as remainder of (id,count,0000) divided by 1_0011.
  function automatic logic [3:0] crc_model(input logic [1:0] id, input logic [CL-1:0] c);
    logic [2+CL+4-1:0] r;
    r = {id, c, 4'b0000};
    for (int i = 2 + CL + 3; i >= 4; i--)
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [FW-1:0] frame_model(input logic [1:0] id, input logic [CL-1:0] c);
    return {4'b1010, id, c, crc_model(id, c)};
  endfunction

  // scan monitor results / options
  logic [FW-1:0] frames [NCH];
  int nframes, done_n, clr_first, clr_cnt, lat_first, lat_cnt, overlap, bad_idle, fs_cnt;
  int opt_abort_frame = -1, opt_drop_cont_frame = -1, opt_start_pulse_n = -1;
  bit opt_scramble = 0;

  // Called at the negedge right after the start edge (n=0).
  task automatic watch(input int limit);
    int nb, aborted_at;
    logic [FW-1:0] cur;
    nb = 0; aborted_at = -1; cur = '0;
    nframes = 0; done_n = -1; clr_first = -1; clr_cnt = 0; lat_first = -1;
    lat_cnt = 0; overlap = 0; bad_idle = 0; fs_cnt = 0;
    for (int i = 0; i < NCH; i++) frames[i] = '0;
    for (int n = 0; n < limit; n++) begin
      if (ctr_reset) begin if (clr_first < 0) clr_first = n; clr_cnt++; end
      if (latch_counter) begin if (lat_first < 0) lat_first = n; lat_cnt++; end
      if (ctr_reset && latch_counter) overlap++;
      if (!serial_valid && serial_bit) bad_idle++;
      if (serial_valid) begin
        if (frame_start) begin cur = '0; nb = 0; fs_cnt++; end
        cur = {cur[FW-2:0], serial_bit};
        nb++;
        if (nb == FW) begin
          if (nframes < NCH) frames[nframes] = cur;
          nframes++;
        end
      end
      if (aborted_at >= 0 && n == aborted_at + 1) begin
        chk("abort_serial_valid", serial_valid, 0);
        chk("abort_busy", busy, 0);
      end
      if (done) begin done_n = n; break; end
      start = (n == opt_start_pulse_n);
      if (opt_scramble && serial_valid) counts = 60'({$urandom, $urandom});
      if (opt_abort_frame >= 0 && aborted_at < 0 && nframes == opt_abort_frame
          && serial_valid && nb == 5) begin
        ena = 1'b0;
        aborted_at = n;
      end
      if (opt_drop_cont_frame >= 0 && nframes == opt_drop_cont_frame && serial_valid)
        continuous = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic kick(input logic [15:0] g, input logic [NCH*CL-1:0] c);
    @(negedge clk);
    gate_cycles = g; counts = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0]   g;
    logic [CL-1:0] c0, c1, c2;
    bit            scr;
    int            pulse_n;
    int            exp_lat;
    int            exp_gate;
  } vec_t;

  vec_t tbl [3];

  initial begin
    logic [CL-1:0] cv [NCH];
    logic [CL-1:0] flipped;

    tbl[0] = '{16'd100, 20'h00000, 20'h00000, 20'h00000, 1'b0, 50, 205, 100};
    tbl[1] = '{16'd0,   20'h12345, 20'hFFFFF, 20'h00001, 1'b1, -1, 106, 1};
    tbl[2] = '{16'd3,   20'hABCDE, 20'h80000, 20'h7FFFF, 1'b0, -1, 108, 3};

    // reset with start held high
    reset = 1'b1; ena = 1'b1; start = 1'b1; continuous = 1'b0;
    gate_cycles = 16'd3; counts = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {ctr_reset, latch_counter, serial_bit, serial_valid, frame_start, busy, done}, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    watch(2000);
    chk("rst_clr_first", clr_first, 0);
    chk("rst_clr_cnt", clr_cnt, 4);
    chk("rst_lat_first", lat_first, 7);
    chk("rst_overlap", overlap, 0);
    chk("rst_done_lat", done_n, 108);

    // table-driven scans
    for (int v = 0; v < 3; v++) begin
      opt_scramble = tbl[v].scr;
      opt_start_pulse_n = tbl[v].pulse_n;
      cv[0] = tbl[v].c0; cv[1] = tbl[v].c1; cv[2] = tbl[v].c2;
      kick(tbl[v].g, {tbl[v].c2, tbl[v].c1, tbl[v].c0});
      watch(2000);
      chk($sformatf("v%0d_done_lat", v), done_n, tbl[v].exp_lat);
      chk($sformatf("v%0d_clr_cnt", v), clr_cnt, 4);
      chk($sformatf("v%0d_lat_cnt", v), lat_cnt, 4);
      chk($sformatf("v%0d_gate_len", v), lat_first - (clr_first + clr_cnt), tbl[v].exp_gate);
      chk($sformatf("v%0d_overlap", v), overlap, 0);
      chk($sformatf("v%0d_idle_bit", v), bad_idle, 0);
      chk($sformatf("v%0d_nframes", v), nframes, NCH);
      chk($sformatf("v%0d_frame_starts", v), fs_cnt, NCH);
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("v%0d_frame%0d", v, ch), frames[ch], frame_model(2'(ch), cv[ch]));
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      if (v == 0) begin
        chk("zero_frame0", frames[0], 30'h2800_0000);
        chk("zero_crc_ch1", frames[1][3:0], 4'hA);
        chk("zero_crc_ch2", frames[2][3:0], 4'h7);
      end
      if (v == 1) begin
        flipped = cv[1] ^ 20'h00080;
        chk("flip_detect", crc_model(2'd1, flipped) != frames[1][3:0], 1);
      end
    end
    opt_scramble = 0; opt_start_pulse_n = -1;

    // continuous: back-to-back scans, gate_cycles re-captured at DONE
    continuous = 1'b1;
    kick(16'd5, {20'h00003, 20'h00002, 20'h00001});
    gate_cycles = 16'd7;
    watch(2000);
    chk("cont_done_lat1", done_n, 110);
    @(negedge clk);
    chk("cont_restart_clr", ctr_reset, 1);
    chk("cont_restart_busy", busy, 1);
    opt_drop_cont_frame = 0;
    watch(2000);
    chk("cont_done_lat2", done_n, 112);
    chk("cont_frame2", frames[2], frame_model(2'd2, 20'h00003));
    @(negedge clk);
    chk("cont_end_busy", busy, 0);
    chk("cont_end_clr", ctr_reset, 0);
    opt_drop_cont_frame = -1;

    // ena low during the second frame
    opt_abort_frame = 1;
    kick(16'd2, {20'h0F0F0, 20'h55555, 20'hAAAAA});
    watch(300);
    chk("abort_no_done", done_n, -1);
    chk("abort_nframes", nframes, 1);
    opt_abort_frame = -1;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
